module_clkdiv_multi: RTL and testbench
======================================

Name: module_clkdiv_multi

Overview:
- Multi-channel programmable tick/clock-enable generator.
- Each channel divides the system clock by a runtime-loadable divisor. It produces a one-cycle tick and a 50%-duty toggle wave.
- Channels run in periodic or one-shot mode.
- Feeds display refresh, debounce and UART timing blocks in place of fixed-count dividers.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 20, divisor/counter width in bits.
- DEFAULT_DIV, 1000000, divisor loaded at reset; must satisfy 1 <= DEFAULT_DIV <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en_i  input  1  global count enable.
- sync_i  input  1  one-cycle strobe: restart all channels phase-aligned.
- cfg_we_i  input  1  configuration write strobe.
- cfg_ch_i  input  max(1,$clog2(N_CH))  channel index for the write.
- cfg_div_i  input  CNT_W  new divisor.
- cfg_mode_i  input  1  0 = periodic, 1 = one-shot.
- tick_o  output  N_CH  per-channel one-cycle tick, registered.
- wave_o  output  N_CH  per-channel toggle wave, registered.
- busy_o  output  N_CH  per-channel armed flag.

Behaviour:
- Reset values (rst high at an edge):
  - div = DEFAULT_DIV; mode = periodic; cnt = 0.
  - tick_o = 0; wave_o = 0; busy_o = all 1.
- Per channel, at each edge with rst low, priority is highest first:
  1. cfg write to this channel.
  2. sync_i.
  3. Counting.
- cfg write (cfg_we_i=1, cfg_ch_i==ch):
  - div <= cfg_div_i; mode <= cfg_mode_i.
  - cnt <= 0; wave <= 0; tick <= 0; armed <= 1.
  - A coincident terminal count is discarded (no tick).
  - cfg_ch_i >= N_CH: write ignored.
- sync_i (no write to this channel): cnt <= 0, wave <= 0, tick <= 0, armed <= 1; div/mode unchanged.
  - sync_i together with a write to channel k: k takes the write, all others take sync. The end state is identical.
- Counting, when en_i=1, armed=1 and div != 0:
  - If cnt == div-1: cnt <= 0, tick <= 1, wave <= ~wave. If mode is one-shot, armed <= 0.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- Latency:
  - The first tick_o is high for exactly one cycle after the D-th enabled edge following reset, write or sync.
  - Tick period is D cycles; wave period is 2D cycles.
  - div=1 gives tick_o constantly high and wave_o toggling every cycle.
- en_i=0: cnt and wave hold; tick <= 0. Enabled edges are counted, not wall cycles.
- div=0: channel halted. cnt held at 0, tick 0, wave holds, busy_o reflects armed.
- One-shot: after its single tick the channel is idle (busy_o=0). cnt=0, wave holds toggled value, no further ticks until a write or sync.
- Counter never exceeds div-1.
  - A write of a smaller div mid-count restarts from 0, so there is no overshoot or wrap through 2^CNT_W.
- Reset mid-operation overrides everything in the same edge.

Decomposition:
- Package pkg_clkdiv:
  - typedef enum logic {MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1} clkdiv_mode_t.
  - Default width constants.
- Sub-module module_clkdiv_chan: one channel holding div/mode/cnt/armed/wave/tick registers.
  - Inputs: ld, ld_div, ld_mode, sync, en.
- Top: write decoder plus generate loop of N_CH instances.

Test Plan:
- Reset, en_i=1, DEFAULT_DIV overridden to 5 -> tick_o[0] high after the 5th edge, then every 5 cycles; wave_o[0] period 10; all channels aligned.
- Write ch2 div=3 periodic, ch1 div=4 one-shot -> ch2 ticks every 3 cycles; ch1 ticks once after 4 edges, busy_o[1]=0 afterwards with no further ticks; rewrite ch1 -> re-armed.
- en_i low for 7 cycles mid-count on div=5 -> tick delayed by exactly 7 cycles, wave unchanged during the pause, tick_o=0 while disabled.
- Edge cases:
  - div=1 -> tick_o constant 1, wave toggles every cycle.
  - div=0 -> no ticks, cnt 0.
  - div=2^20-1 -> first tick after 1048575 edges.
- Write to ch0 in the same cycle its cnt==div-1 -> no tick, cnt=0. Concurrent sync_i with write to ch3 -> all channels restart aligned, ch3 with new div.
- Assert rst mid-count, and write cfg_ch_i=5 with N_CH=4 -> all outputs return to reset values next cycle; the out-of-range write changes nothing.

Source files
------------

// File: rtl/module_clkdiv_multi_pkg.sv
// Shared types and default sizing for the multi-channel tick generator.
package pkg_clkdiv;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } clkdiv_mode_t;

  localparam int N_CH_DEF        = 4;
  localparam int CNT_W_DEF       = 20;
  localparam int DEFAULT_DIV_DEF = 1000000;

  // Width of a channel index; a single channel still needs a 1-bit port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_clkdiv_multi_chan.sv
// One divider channel: holds its divisor, mode and phase, emits a registered
// one-cycle tick on terminal count plus a toggle wave at half the tick rate.
module module_clkdiv_chan
  import pkg_clkdiv::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  input  clkdiv_mode_t     ld_mode,
  output logic             tick,
  output logic             wave,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_reg;
  clkdiv_mode_t     mode_reg;
  logic             armed_reg;
  logic             wave_reg;
  logic             tick_reg;

  // Load beats sync beats counting; a load on the terminal-count edge drops
  // that tick because the phase restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg   <= CNT_W'(DEFAULT_DIV);
      mode_reg  <= MODE_PERIODIC;
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
      wave_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else if (ld) begin
      div_reg   <= ld_div;
      mode_reg  <= ld_mode;
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
      wave_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else if (sync) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
      wave_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else if (en && armed_reg && (div_reg != '0)) begin
      if (cnt_reg == (div_reg - ONE)) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
        wave_reg <= ~wave_reg;
        if (mode_reg == MODE_ONESHOT) begin
          armed_reg <= 1'b0;
        end
      end else begin
        cnt_reg  <= cnt_reg + ONE;
        tick_reg <= 1'b0;
      end
    end else begin
      // Paused, halted (div 0) or spent one-shot: phase and wave hold.
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;
  assign wave = wave_reg;
  assign busy = armed_reg;

endmodule

// File: rtl/module_clkdiv_multi.sv
// Multi-channel programmable tick/clock-enable generator: a config write
// decoder fanning out to N_CH independent divider channels.
module module_clkdiv_multi
  import pkg_clkdiv::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W       = ch_idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  wave_o,
  output logic [N_CH-1:0]  busy_o
);

  logic [N_CH-1:0] ld_vec;
  clkdiv_mode_t    cfg_mode;

  assign cfg_mode = clkdiv_mode_t'(cfg_mode_i);

  // Indices at or beyond N_CH match no channel, so such writes vanish.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ld_vec[gi] = cfg_we_i && (cfg_ch_i == CH_W'(gi));

      module_clkdiv_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en_i),
        .sync    (sync_i),
        .ld      (ld_vec[gi]),
        .ld_div  (cfg_div_i),
        .ld_mode (cfg_mode),
        .tick    (tick_o[gi]),
        .wave    (wave_o[gi]),
        .busy    (busy_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_module_clkdiv_multi.sv
// Directed bench for the tick generator: expectations are queued before each
// edge from closed-form phase arithmetic and checked just after the edge.
module tb_module_clkdiv_multi;

  localparam int NCH = 5;
  localparam int CW  = 20;
  localparam int DEF = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en_i = 1'b0;
  logic           sync_i = 1'b0;
  logic           cfg_we_i = 1'b0;
  logic [2:0]     cfg_ch_i = '0;
  logic [CW-1:0]  cfg_div_i = '0;
  logic           cfg_mode_i = 1'b0;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] wave_o;
  logic [NCH-1:0] busy_o;

  module_clkdiv_multi #(
    .N_CH        (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .sync_i     (sync_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_mode_i (cfg_mode_i),
    .tick_o     (tick_o),
    .wave_o     (wave_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // sel: 0 = tick, 1 = wave, 2 = busy
  typedef struct {
    string tag;
    int    sel;
    int    ch;
    logic  exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic obs(input int sel, input int c);
    case (sel)
      0:       return tick_o[c];
      1:       return wave_o[c];
      default: return busy_o[c];
    endcase
  endfunction

  task automatic exp_b(input string tag, input int sel, input int c, input logic v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ch = c; e.exp = v;
    sb.push_back(e);
  endtask

  // Periodic channel n enabled edges after a restart with divisor d.
  task automatic exp_phase(input string tag, input int c, input int n, input int d);
    exp_b(tag, 0, c, (n % d) == 0);
    exp_b(tag, 1, c, ((n / d) % 2) == 1);
  endtask

  task automatic exp_restart(input string tag, input int c);
    exp_b(tag, 0, c, 1'b0);
    exp_b(tag, 1, c, 1'b0);
    exp_b(tag, 2, c, 1'b1);
  endtask

  // One-shot channel with divisor d, n enabled edges after arming.
  task automatic exp_oneshot(input string tag, input int c, input int n, input int d);
    exp_b(tag, 0, c, n == d);
    exp_b(tag, 1, c, n >= d);
    exp_b(tag, 2, c, n < d);
  endtask

  // Advance one edge, check every queued expectation, drop one-cycle strobes.
  task automatic step();
    exp_t e;
    logic o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel, e.ch);
      n_total++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s ch%0d sel%0d observed=%b expected=%b", e.tag, e.ch, e.sel, o, e.exp);
    end
    cfg_we_i = 1'b0;
    sync_i   = 1'b0;
  endtask

  task automatic cfg(input int c, input int d, input logic m);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = 3'(c);
    cfg_div_i  = CW'(d);
    cfg_mode_i = m;
    $display("cfg write ch=%0d div=%0d mode=%0d", c, d, m);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) exp_restart("reset", c);
    step();
    $display("reset checked");

    // Default divisor on all channels, aligned
    rst = 1'b0; en_i = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      for (int c = 0; c < NCH; c++) begin
        exp_phase("default_div", c, n, DEF);
        exp_b("default_busy", 2, c, 1'b1);
      end
      step();
    end
    $display("default divisor phase checked");

    // ch2 periodic div 3, then ch1 one-shot div 4
    cfg(2, 3, 1'b0);
    exp_restart("wr_ch2", 2);
    step();
    cfg(1, 4, 1'b1);
    exp_restart("wr_ch1", 1);
    exp_phase("ch2_div3", 2, 1, 3);
    step();
    for (int n = 1; n <= 12; n++) begin
      exp_oneshot("ch1_oneshot", 1, n, 4);
      exp_phase("ch2_div3", 2, n + 1, 3);
      step();
    end
    cfg(1, 4, 1'b1);
    exp_restart("rearm_ch1", 1);
    step();
    for (int n = 1; n <= 4; n++) begin
      exp_oneshot("ch1_rearmed", 1, n, 4);
      step();
    end
    $display("one-shot and rewrite checked");

    // Sync restart, then a 7-cycle pause mid-count on ch0
    sync_i = 1'b1;
    for (int c = 0; c < NCH; c++) exp_restart("sync", c);
    step();
    for (int n = 1; n <= 7; n++) begin
      exp_phase("pre_pause", 0, n, DEF);
      step();
    end
    en_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      exp_b("pause_tick", 0, 0, 1'b0);
      exp_b("pause_wave", 1, 0, 1'b1);
      exp_b("pause_tick", 0, 3, 1'b0);
      step();
    end
    en_i = 1'b1;
    for (int n = 8; n <= 12; n++) begin
      exp_phase("post_pause", 0, n, DEF);
      step();
    end
    $display("enable pause checked");

    // div = 1: tick every cycle, wave toggles each cycle
    cfg(3, 1, 1'b0);
    exp_restart("wr_div1", 3);
    step();
    for (int n = 1; n <= 6; n++) begin
      exp_phase("div1", 3, n, 1);
      step();
    end

    // div = 0: halted
    cfg(4, 0, 1'b0);
    exp_restart("wr_div0", 4);
    step();
    for (int k = 0; k < 10; k++) begin
      exp_restart("div0_halt", 4);
      step();
    end

    // Largest divisor: no early tick
    cfg(4, (1 << CW) - 1, 1'b0);
    exp_restart("wr_divmax", 4);
    step();
    for (int k = 0; k < 300; k++) begin
      exp_b("divmax_tick", 0, 4, 1'b0);
      step();
    end
    $display("div edge cases checked");

    // Write landing on terminal count discards the tick
    sync_i = 1'b1;
    exp_restart("sync2", 0);
    step();
    for (int n = 1; n <= 4; n++) begin
      exp_phase("pre_tc", 0, n, DEF);
      step();
    end
    cfg(0, DEF, 1'b0);
    exp_restart("wr_on_tc", 0);
    step();
    for (int n = 1; n <= 5; n++) begin
      exp_phase("after_tc_wr", 0, n, DEF);
      step();
    end
    $display("write on terminal count checked");

    // Sync together with a write to ch3
    sync_i = 1'b1;
    cfg(3, 2, 1'b0);
    for (int c = 0; c < NCH; c++) exp_restart("sync_wr", c);
    step();
    for (int n = 1; n <= 10; n++) begin
      exp_phase("sw_ch0", 0, n, DEF);
      exp_oneshot("sw_ch1", 1, n, 4);
      exp_phase("sw_ch2", 2, n, 3);
      exp_phase("sw_ch3", 3, n, 2);
      exp_b("sw_ch4", 0, 4, 1'b0);
      step();
    end

    // Out-of-range write has no effect
    cfg(5, 2, 1'b1);
    exp_phase("oor_ch0", 0, 11, DEF);
    exp_phase("oor_ch2", 2, 11, 3);
    exp_phase("oor_ch3", 3, 11, 2);
    exp_b("oor_ch1", 2, 1, 1'b0);
    step();
    $display("sync with write and out-of-range write checked");

    // Reset mid-count restores defaults everywhere
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) exp_restart("mid_reset", c);
    step();
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      for (int c = 0; c < NCH; c++) begin
        exp_phase("post_reset", c, n, DEF);
        exp_b("post_reset_busy", 2, c, 1'b1);
      end
      step();
    end
    $display("mid-run reset checked");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
